scoreboard_hazard_unit: RTL and testbench

//  Parametrised successor to the single-cycle forward/stall hazard unit. Used when the EX stage holds

---
 rtl/scoreboard_hazard_unit_if.sv | 51 +++++
 rtl/scoreboard_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit_if
// Bundle between the ID stage and the scoreboard hazard unit.
//   master : ID-stage side. Drives the decoded instruction fields and receives
//            the issue/stall/flush/forward decisions.
//   slave  : hazard unit side.
// Signals (master -> slave):
//   valid_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, rd_ID, RegWrite_ID,
//   fu_ID (00 ALU, 01 LOAD, 10 MUL, 11 DIV), Branch_ID
// Signals (slave -> master):
//   issue_ID, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
//   forward_ctrl_A, forward_ctrl_B, div_busy, stall_cnt
// ---------------------------------------------------------------------------
interface scoreboard_hazard_unit_if #(
    parameter int RW     = 5,
    parameter int PERF_W = 32
);
    logic              valid_ID;
    logic [RW-1:0]     rs1_ID;
    logic [RW-1:0]     rs2_ID;
    logic              rs1use_ID;
    logic              rs2use_ID;
    logic [RW-1:0]     rd_ID;
    logic              RegWrite_ID;
    logic [1:0]        fu_ID;
    logic              Branch_ID;

    logic              issue_ID;
    logic              PC_EN_IF;
    logic              reg_FD_EN;
    logic              reg_FD_flush;
    logic              reg_DE_flush;
    logic [2:0]        forward_ctrl_A;
    logic [2:0]        forward_ctrl_B;
    logic              div_busy;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output valid_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID,
               rd_ID, RegWrite_ID, fu_ID, Branch_ID,
        input  issue_ID, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, div_busy, stall_cnt
    );

    modport slave (
        input  valid_ID, rs1_ID, rs2_ID, rs1use_ID, rs2use_ID,
               rd_ID, RegWrite_ID, fu_ID, Branch_ID,
        output issue_ID, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, div_busy, stall_cnt
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit
// Scoreboard-based hazard unit for an EX stage built from variable-latency
// functional units (ALU, LOAD, pipelined MUL, non-pipelined DIV).
// Every architectural register r (x0 excluded) carries busy/cnt/fu: cnt is the
// number of cycles until the pending result for r appears on the result bus
// of unit fu (0 = this cycle). From that the unit decides RAW, WAW,
// write-port and DIV structural stalls, bus forwarding and branch flush.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   sb   : slave side of scoreboard_hazard_unit_if (ID fields in, control out)
// All outputs are combinational from the ID fields and the registered state;
// the scoreboard itself updates on the next clock edge.
// ---------------------------------------------------------------------------
module scoreboard_hazard_unit #(
    parameter int NREG     = 32,
    parameter int RW       = $clog2(NREG),
    parameter int CNT_W    = 5,
    parameter int LAT_ALU  = 1,
    parameter int LAT_LOAD = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 16,
    parameter int PERF_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    scoreboard_hazard_unit_if.slave sb
);

    localparam logic [1:0] FU_LOAD = 2'b01;
    localparam logic [1:0] FU_MUL  = 2'b10;
    localparam logic [1:0] FU_DIV  = 2'b11;

    logic [NREG-1:0]   busy_reg, busy_next;
    logic [CNT_W-1:0]  cnt_reg  [NREG];
    logic [CNT_W-1:0]  cnt_next [NREG];
    logic [1:0]        fu_reg   [NREG];
    logic [1:0]        fu_next  [NREG];
    logic [NREG-1:0]   port_hit;

    logic              div_busy_reg;
    logic [CNT_W-1:0]  div_cnt_reg;
    logic [PERF_W-1:0] stall_cnt_reg;

    logic [CNT_W-1:0]  lat_id;
    logic              rs1_ready, rs2_ready;
    logic              raw_haz, waw_haz, port_haz, strc_haz;
    logic              stall, issue;
    logic [2:0]        fwd_a, fwd_b;

    // Latency of the unit the ID instruction targets.
    always_comb begin
        lat_id = CNT_W'(LAT_ALU);
        case (sb.fu_ID)
            FU_LOAD: lat_id = CNT_W'(LAT_LOAD);
            FU_MUL:  lat_id = CNT_W'(LAT_MUL);
            FU_DIV:  lat_id = CNT_W'(LAT_DIV);
            default: lat_id = CNT_W'(LAT_ALU);
        endcase
    end

    // A source whose result is on the bus this cycle (cnt==0) is ready: it is
    // picked up by forwarding rather than stalled on.
    assign rs1_ready = !sb.rs1use_ID || (sb.rs1_ID == '0) ||
                       !busy_reg[sb.rs1_ID] || (cnt_reg[sb.rs1_ID] == '0);
    assign rs2_ready = !sb.rs2use_ID || (sb.rs2_ID == '0) ||
                       !busy_reg[sb.rs2_ID] || (cnt_reg[sb.rs2_ID] == '0);

    assign raw_haz  = !rs1_ready || !rs2_ready;
    // A younger write that would land no later than the older one must wait,
    // otherwise the older result would overwrite it.
    assign waw_haz  = sb.RegWrite_ID && (sb.rd_ID != '0) &&
                      busy_reg[sb.rd_ID] && (lat_id <= cnt_reg[sb.rd_ID]);
    // Single regfile write port: no two results may land in the same cycle.
    assign port_haz = |port_hit;
    assign strc_haz = (sb.fu_ID == FU_DIV) && div_busy_reg;

    assign stall = sb.valid_ID && (raw_haz || waw_haz || port_haz || strc_haz);
    assign issue = sb.valid_ID && !stall;

    // Per-register scoreboard next state. An issue claiming r takes priority
    // over retiring the old entry in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign port_hit[gi]  = 1'b0;
                assign busy_next[gi] = 1'b0;
                assign cnt_next[gi]  = '0;
                assign fu_next[gi]   = 2'b00;
            end else begin : g_xr
                logic claim;
                logic counting;
                assign claim        = issue && sb.RegWrite_ID && (sb.rd_ID == RW'(gi));
                assign counting     = busy_reg[gi] && (cnt_reg[gi] != '0);
                assign port_hit[gi] = busy_reg[gi] && (cnt_reg[gi] == lat_id);
                assign busy_next[gi] = claim ? 1'b1 : counting;
                assign cnt_next[gi]  = claim    ? lat_id - CNT_W'(1) :
                                       counting ? cnt_reg[gi] - CNT_W'(1) : cnt_reg[gi];
                assign fu_next[gi]   = claim ? sb.fu_ID : fu_reg[gi];
            end
        end
    endgenerate

    // Forwarding select: {1, fu} when the source's result is on that bus now.
    always_comb begin
        fwd_a = 3'b000;
        fwd_b = 3'b000;
        if (sb.rs1use_ID && (sb.rs1_ID != '0) && busy_reg[sb.rs1_ID] &&
            (cnt_reg[sb.rs1_ID] == '0))
            fwd_a = {1'b1, fu_reg[sb.rs1_ID]};
        if (sb.rs2use_ID && (sb.rs2_ID != '0) && busy_reg[sb.rs2_ID] &&
            (cnt_reg[sb.rs2_ID] == '0))
            fwd_b = {1'b1, fu_reg[sb.rs2_ID]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg      <= '0;
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= '0;
                fu_reg[i]  <= 2'b00;
            end
            div_busy_reg  <= 1'b0;
            div_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= cnt_next[i];
                fu_reg[i]  <= fu_next[i];
            end
            // DIV occupancy ends one cycle before its result cycle edge, so
            // the divider is free again in the cycle its result is written.
            if (issue && (sb.fu_ID == FU_DIV)) begin
                div_busy_reg <= 1'(LAT_DIV > 1);
                div_cnt_reg  <= CNT_W'(LAT_DIV - 1);
            end else if (div_busy_reg) begin
                if (div_cnt_reg <= CNT_W'(1))
                    div_busy_reg <= 1'b0;
                div_cnt_reg <= div_cnt_reg - CNT_W'(1);
            end
            if (stall && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
        end
    end

    assign sb.issue_ID       = issue;
    assign sb.PC_EN_IF       = !stall;
    assign sb.reg_FD_EN      = !stall;
    assign sb.reg_FD_flush   = issue && sb.Branch_ID;
    assign sb.reg_DE_flush   = stall;
    assign sb.forward_ctrl_A = fwd_a;
    assign sb.forward_ctrl_B = fwd_b;
    assign sb.div_busy       = div_busy_reg;
    assign sb.stall_cnt      = stall_cnt_reg;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
// Directed scenarios for forwarding, load-use, DIV occupancy, WAW/port
// conflicts, branch flush and asynchronous reset, followed by a randomized
// run checked against a timeline reference model (absolute result cycles per
// register and an absolute "divider free" cycle).
// ---------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;

    localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, MUL = 2'b10, DIV = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scoreboard_hazard_unit_if #(.RW(5), .PERF_W(32)) sb_if ();

    scoreboard_hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Shadow of the driven ID fields, used by the reference model.
    logic       in_valid, in_u1, in_u2, in_rw, in_br;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic [1:0] in_fu;

    // Reference model: timeline of pending results.
    bit         m_pend [32];
    longint     m_due  [32];
    logic [1:0] m_fu   [32];
    longint     m_now, m_div_free;
    int         m_stall;
    logic       e_issue, e_stall, e_divb;
    logic [2:0] e_fa, e_fb;

    function automatic logic [5:0] ctl();
        return {sb_if.issue_ID, sb_if.PC_EN_IF, sb_if.reg_FD_EN,
                sb_if.reg_FD_flush, sb_if.reg_DE_flush, sb_if.div_busy};
    endfunction

    function automatic int lat_of(input logic [1:0] f);
        case (f)
            ALU:     return 1;
            LOAD:    return 2;
            MUL:     return 3;
            default: return 16;
        endcase
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic [1:0] fu, input logic br);
        in_valid = v; in_rs1 = rs1; in_u1 = u1; in_rs2 = rs2; in_u2 = u2;
        in_rd = rd; in_rw = rw; in_fu = fu; in_br = br;
        sb_if.valid_ID    = v;
        sb_if.rs1_ID      = rs1;
        sb_if.rs1use_ID   = u1;
        sb_if.rs2_ID      = rs2;
        sb_if.rs2use_ID   = u2;
        sb_if.rd_ID       = rd;
        sb_if.RegWrite_ID = rw;
        sb_if.fu_ID       = fu;
        sb_if.Branch_ID   = br;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) next_cycle();
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 1'b0;
            m_due[r]  = 0;
            m_fu[r]   = 2'b00;
        end
        m_now = 0; m_div_free = 0; m_stall = 0;
    endtask

    task automatic model_eval();
        int L;
        bit raw, waw, port, strc;
        L    = lat_of(in_fu);
        raw  = (in_u1 && in_rs1 != 0 && m_pend[in_rs1] && m_due[in_rs1] != m_now) ||
               (in_u2 && in_rs2 != 0 && m_pend[in_rs2] && m_due[in_rs2] != m_now);
        waw  = in_rw && in_rd != 0 && m_pend[in_rd] && (m_now + L <= m_due[in_rd]);
        port = 1'b0;
        for (int r = 1; r < 32; r++)
            if (m_pend[r] && m_due[r] == m_now + L) port = 1'b1;
        strc    = (in_fu == DIV) && (m_now < m_div_free);
        e_stall = in_valid && (raw || waw || port || strc);
        e_issue = in_valid && !e_stall;
        e_divb  = m_now < m_div_free;
        e_fa = (in_u1 && in_rs1 != 0 && m_pend[in_rs1] && m_due[in_rs1] == m_now) ?
               {1'b1, m_fu[in_rs1]} : 3'b000;
        e_fb = (in_u2 && in_rs2 != 0 && m_pend[in_rs2] && m_due[in_rs2] == m_now) ?
               {1'b1, m_fu[in_rs2]} : 3'b000;
    endtask

    task automatic model_commit();
        for (int r = 1; r < 32; r++)
            if (m_pend[r] && m_due[r] == m_now) m_pend[r] = 1'b0;
        if (e_issue && in_rw && in_rd != 0) begin
            m_pend[in_rd] = 1'b1;
            m_due[in_rd]  = m_now + lat_of(in_fu);
            m_fu[in_rd]   = in_fu;
        end
        if (e_issue && in_fu == DIV) m_div_free = m_now + 16;
        if (e_stall) m_stall++;
        m_now++;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        $display("[reset] idle state under reset");
        n_vec++;
        if (ctl() !== 6'b011000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want %b", ctl(), 6'b011000);
        end
        n_vec++;
        if ({sb_if.forward_ctrl_A, sb_if.forward_ctrl_B} !== 6'b000000 || sb_if.stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_fwd_cnt: got fwd %b cnt %0d want 000000 and 0",
                              {sb_if.forward_ctrl_A, sb_if.forward_ctrl_B}, sb_if.stall_cnt);
        end
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, DIV, 1'b0);
        #1;
        $display("[reset] DIV reading x5,x6 under reset");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL reset_issue: got %b want %b", ctl(), 6'b111000);
        end
        idle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_alu_forward();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, ALU, 1'b0);
        @(negedge clk);
        $display("[alu_fwd] t0 ALU x5");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL alu_fwd_t0: got %b want %b", ctl(), 6'b111000);
        end
        next_cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, ALU, 1'b0);
        @(negedge clk);
        $display("[alu_fwd] t1 ALU reads x5");
        n_vec++;
        if (ctl() !== 6'b111000 || sb_if.forward_ctrl_A !== 3'b100) begin
            n_err++; $display("FAIL alu_fwd_t1: got ctl %b fwdA %b want 111000 100",
                              ctl(), sb_if.forward_ctrl_A);
        end
        next_cycle();
        drain(4);
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, LOAD, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd11, 1'b1, ALU, 1'b0);
        @(negedge clk);
        $display("[load_use] t1 ALU reads x6");
        n_vec++;
        if (ctl() !== 6'b000010) begin
            n_err++; $display("FAIL load_use_stall: got %b want %b", ctl(), 6'b000010);
        end
        next_cycle();
        @(negedge clk);
        $display("[load_use] t2 ALU reads x6");
        n_vec++;
        if (ctl() !== 6'b111000 || sb_if.forward_ctrl_B !== 3'b101) begin
            n_err++; $display("FAIL load_use_issue: got ctl %b fwdB %b want 111000 101",
                              ctl(), sb_if.forward_ctrl_B);
        end
        next_cycle();
        drain(4);
    endtask

    task automatic test_div_struct();
        pulse_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, DIV, 1'b0);
        @(negedge clk);
        $display("[div] t0 DIV x7");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL div_t0: got %b want %b", ctl(), 6'b111000);
        end
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, DIV, 1'b0);
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            $display("[div] t%0d DIV x8 waiting", t);
            n_vec++;
            if (ctl() !== 6'b000011) begin
                n_err++; $display("FAIL div_stall_t%0d: got %b want %b", t, ctl(), 6'b000011);
            end
            next_cycle();
        end
        @(negedge clk);
        $display("[div] t16 DIV x8");
        n_vec++;
        if (ctl() !== 6'b111000 || sb_if.stall_cnt !== 32'd15) begin
            n_err++; $display("FAIL div_issue: got ctl %b cnt %0d want 111000 15",
                              ctl(), sb_if.stall_cnt);
        end
        next_cycle();
        drain(20);
    endtask

    task automatic test_waw_port();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, MUL, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, ALU, 1'b0);
        // MUL result lands at t3; the ALU write to x9 may only issue at t3.
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            $display("[waw] t%0d ALU x9 behind MUL x9", t);
            n_vec++;
            if (ctl() !== 6'b000010) begin
                n_err++; $display("FAIL waw_stall_t%0d: got %b want %b", t, ctl(), 6'b000010);
            end
            next_cycle();
        end
        @(negedge clk);
        $display("[waw] t3 ALU x9");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL waw_issue: got %b want %b", ctl(), 6'b111000);
        end
        next_cycle();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, ALU, 1'b0);
        @(negedge clk);
        $display("[waw] t4 read x9");
        n_vec++;
        if (sb_if.issue_ID !== 1'b1 || sb_if.forward_ctrl_A !== 3'b100) begin
            n_err++; $display("FAIL waw_final_fu: got issue %b fwdA %b want 1 100",
                              sb_if.issue_ID, sb_if.forward_ctrl_A);
        end
        next_cycle();
        drain(4);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, LOAD, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, ALU, 1'b0);
        @(negedge clk);
        $display("[port] t1 ALU x4 vs LOAD x3");
        n_vec++;
        if (ctl() !== 6'b000010) begin
            n_err++; $display("FAIL port_stall: got %b want %b", ctl(), 6'b000010);
        end
        next_cycle();
        @(negedge clk);
        $display("[port] t2 ALU x4");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL port_issue: got %b want %b", ctl(), 6'b111000);
        end
        next_cycle();
        drain(4);
    endtask

    task automatic test_branch();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, ALU, 1'b1);
        @(negedge clk);
        $display("[branch] taken, no hazard");
        n_vec++;
        if (ctl() !== 6'b111100) begin
            n_err++; $display("FAIL branch_flush: got %b want %b", ctl(), 6'b111100);
        end
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, LOAD, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b1);
        @(negedge clk);
        $display("[branch] taken during RAW");
        n_vec++;
        if (ctl() !== 6'b000010) begin
            n_err++; $display("FAIL branch_stall: got %b want %b", ctl(), 6'b000010);
        end
        next_cycle();
        @(negedge clk);
        $display("[branch] re-evaluated");
        n_vec++;
        if (ctl() !== 6'b111100) begin
            n_err++; $display("FAIL branch_retry: got %b want %b", ctl(), 6'b111100);
        end
        next_cycle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b1);
        @(negedge clk);
        $display("[branch] invalid ID with branch");
        n_vec++;
        if (ctl() !== 6'b011000) begin
            n_err++; $display("FAIL branch_invalid: got %b want %b", ctl(), 6'b011000);
        end
        next_cycle();
        drain(4);
    endtask

    task automatic test_reset_mid_div();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, DIV, 1'b0);
        next_cycle();
        drain(3);
        @(negedge clk);
        $display("[rst_div] DIV in flight");
        n_vec++;
        if (ctl() !== 6'b011001) begin
            n_err++; $display("FAIL rst_div_busy: got %b want %b", ctl(), 6'b011001);
        end
        rst = 1'b1;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, DIV, 1'b0);
        #1;
        $display("[rst_div] async reset asserted");
        n_vec++;
        if (ctl() !== 6'b111000 || sb_if.forward_ctrl_A !== 3'b000) begin
            n_err++; $display("FAIL rst_div_clear: got ctl %b fwdA %b want 111000 000",
                              ctl(), sb_if.forward_ctrl_A);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        $display("[rst_div] DIV x8 after reset");
        n_vec++;
        if (ctl() !== 6'b111000) begin
            n_err++; $display("FAIL rst_div_issue: got %b want %b", ctl(), 6'b111000);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (sb_if.div_busy !== 1'b1) begin
            n_err++; $display("FAIL rst_div_rebusy: got %b want 1", sb_if.div_busy);
        end
        next_cycle();
        drain(20);
    endtask

    task automatic test_random();
        logic [3:0] f;
        logic [5:0] want;
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        next_cycle();
        rst = 1'b0;
        e_stall = 1'b0;
        for (int i = 0; i < 700; i++) begin
            // A stalled instruction stays in ID, as a real pipeline holds it.
            if (!e_stall) begin
                f = 4'($urandom_range(0, 9));
                set_id(($urandom_range(0, 9) < 8),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                       (f < 4) ? ALU : (f < 6) ? LOAD : (f < 8) ? MUL : (f == 8) ? DIV : ALU,
                       ($urandom_range(0, 5) == 0));
            end
            @(negedge clk);
            model_eval();
            want = {e_issue, !e_stall, !e_stall, e_issue && in_br, e_stall, e_divb};
            $display("[rand %0d] v=%0b fu=%0d rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b issue=%0b",
                     i, in_valid, in_fu, in_rs1, in_u1, in_rs2, in_u2, in_rd, in_rw, e_issue);
            n_vec++;
            if (ctl() !== want) begin
                n_err++; $display("FAIL rand_ctrl@%0d: got %b want %b", i, ctl(), want);
            end
            n_vec++;
            if (sb_if.stall_cnt !== 32'(m_stall)) begin
                n_err++; $display("FAIL rand_stall_cnt@%0d: got %0d want %0d", i, sb_if.stall_cnt, m_stall);
            end
            if (e_issue) begin
                n_vec++;
                if (sb_if.forward_ctrl_A !== e_fa || sb_if.forward_ctrl_B !== e_fb) begin
                    n_err++; $display("FAIL rand_fwd@%0d: got %b/%b want %b/%b", i,
                                      sb_if.forward_ctrl_A, sb_if.forward_ctrl_B, e_fa, e_fb);
                end
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_div_struct();
        test_waw_port();
        test_branch();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
